// File: rtl/dbg_pkg.sv
// Shared definitions for the Debugger Module controllers:
// sequencer state encoding, default bus widths and response error codes.
package dbg_pkg;

    localparam int DBG_DATA_W = 32;
    localparam int DBG_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HALT   = 3'd1,
        ACCESS = 3'd2,
        RESUME = 3'd3,
        RESP   = 3'd4
    } dbg_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_REG = 2'd1,
        ERR_TIMEOUT = 2'd2
    } dbg_err_e;

    function automatic logic dbg_is_err(dbg_err_e code);
        return code != ERR_NONE;
    endfunction

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Saturating cycle counter for halt/resume handshakes.
// 'expired' is high on the LIMIT-th enabled cycle after a clear, so a
// waiting state that exits on it lasts exactly LIMIT cycles.
module dbg_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Count enabled cycles, hold at LIMIT, restart on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CW'(LIMIT))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/dbg_access_ctrl.sv
// Abstract GPR access sequencer: halts the core if needed, performs one
// register-file read or write, restores run state, then responds.
//
// state  | meaning
// IDLE   | ready for a host command
// HALT   | requesting halt, waiting for cpu_halted (bounded)
// ACCESS | single cycle GPR read (data0 load) or write
// RESUME | requesting resume, waiting for cpu_halted low (bounded)
// RESP   | response valid, waiting for host rsp_ready
module dbg_access_ctrl
    import dbg_pkg::*;
#(
    parameter int DATA_W       = DBG_DATA_W,
    parameter int ADDR_W       = DBG_ADDR_W,
    parameter int NUM_REGS     = 32,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_regno,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic              cpu_halt_req,
    output logic              cpu_resume_req,
    input  logic              cpu_halted,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              data0_ld,
    output logic [DATA_W-1:0] data0_in
);
    dbg_state_e        state_q, state_d;
    dbg_err_e          err_q, err_d;
    logic              wr_q;
    logic [ADDR_W-1:0] regno_q;
    logic [DATA_W-1:0] wdata_q;
    logic              was_halted_q;
    logic              accept;
    logic              cnt_clr, cnt_en, cnt_expired;

    assign accept  = (state_q == IDLE) && cmd_valid;
    // Every state entry restarts the wait budget.
    assign cnt_clr = (state_d != state_q);

    dbg_timeout_cnt #(.LIMIT(HALT_TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    // State, error code and command latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            err_q        <= ERR_NONE;
            wr_q         <= 1'b0;
            regno_q      <= '0;
            wdata_q      <= '0;
            was_halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q         <= cmd_write;
                regno_q      <= cmd_regno;
                wdata_q      <= cmd_wdata;
                was_halted_q <= cpu_halted;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_err        = 1'b0;
        cpu_halt_req   = 1'b0;
        cpu_resume_req = 1'b0;
        rf_addr        = '0;
        rf_we          = 1'b0;
        rf_wdata       = '0;
        data0_ld       = 1'b0;
        data0_in       = '0;
        cnt_en         = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    err_d = ERR_NONE;
                    if (int'(cmd_regno) >= NUM_REGS) begin
                        err_d   = ERR_BAD_REG;
                        state_d = RESP;
                    end else if (cpu_halted) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                cpu_halt_req = 1'b1;
                cnt_en       = 1'b1;
                if (cpu_halted) begin
                    state_d = ACCESS;
                end else if (cnt_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            ACCESS: begin
                // Only hold the halt if we were the ones who requested it.
                cpu_halt_req = !was_halted_q;
                rf_addr      = regno_q;
                if (wr_q) begin
                    // x0 is hardwired; the write is dropped but reported as done.
                    rf_we    = (regno_q != '0);
                    rf_wdata = wdata_q;
                end else begin
                    data0_ld = 1'b1;
                    data0_in = (regno_q == '0) ? '0 : rf_rdata;
                end
                state_d = was_halted_q ? RESP : RESUME;
            end
            RESUME: begin
                cpu_resume_req = 1'b1;
                cnt_en         = 1'b1;
                if (!cpu_halted) begin
                    state_d = RESP;
                end else if (cnt_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = dbg_is_err(err_q);
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_access_ctrl.sv
// Bench for dbg_access_ctrl: table of commands with a cycle-level core
// model, expected responses queued at issue and checked at rsp_valid,
// plus hand-written reset-in-flight sequences.
module tb_dbg_access_ctrl;
    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam int NREG = 32;
    localparam int HTO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_regno;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic          cpu_halt_req, cpu_resume_req, cpu_halted;
    logic [AW-1:0] rf_addr;
    logic          rf_we;
    logic [DW-1:0] rf_wdata, rf_rdata;
    logic          data0_ld;
    logic [DW-1:0] data0_in;
    logic [DW-1:0] rf_mem [64];

    always #5 clk = ~clk;

    assign rf_rdata = rf_mem[rf_addr];

    dbg_access_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREG), .HALT_TIMEOUT(HTO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .cpu_halt_req(cpu_halt_req), .cpu_resume_req(cpu_resume_req), .cpu_halted(cpu_halted),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .data0_ld(data0_ld), .data0_in(data0_in)
    );

    // hd/rd: cycles of halt/resume request before the core responds, 0 = never.
    typedef struct {
        logic        wr;
        logic [5:0]  regno;
        logic [31:0] wdata;
        logic        halted;
        int          hd;
        int          rd;
        logic        err;
        int          we_n;
        int          ld_n;
        logic [31:0] d0;
        int          halt_n;
        int          res_n;
        int          lat;
    } vec_t;

    typedef struct {
        logic        err;
        int          we_n;
        int          ld_n;
        logic [31:0] d0;
        logic [5:0]  wa;
        logic [31:0] wd;
        int          halt_n;
        int          res_n;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_bad = 0;

    int halt_delay, resume_delay, req_cnt;
    int o_we, o_ld, o_halt, o_res, o_excl, o_busy_rdy;
    logic [31:0] o_d0, o_wd;
    logic [5:0]  o_wa;

    function automatic vec_t mk(input logic wr, input int regno, input logic [31:0] wdata,
                                input logic halted, input int hd, input int rd,
                                input logic err, input int we_n, input int ld_n,
                                input logic [31:0] d0, input int halt_n, input int res_n,
                                input int lat);
        vec_t v;
        v.wr = wr; v.regno = 6'(regno); v.wdata = wdata; v.halted = halted;
        v.hd = hd; v.rd = rd; v.err = err; v.we_n = we_n; v.ld_n = ld_n;
        v.d0 = d0; v.halt_n = halt_n; v.res_n = res_n; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Core model, evaluated once per cycle at the falling edge.
    task automatic core_step();
        if (cpu_halt_req && !cpu_halted) begin
            req_cnt++;
            if (halt_delay > 0 && req_cnt >= halt_delay) begin
                cpu_halted = 1'b1;
                req_cnt    = 0;
            end
        end else if (cpu_resume_req && cpu_halted) begin
            req_cnt++;
            if (resume_delay > 0 && req_cnt >= resume_delay) begin
                cpu_halted = 1'b0;
                req_cnt    = 0;
            end
        end else begin
            req_cnt = 0;
        end
    endtask

    task automatic observe();
        if (rf_we) begin o_we++; o_wa = rf_addr; o_wd = rf_wdata; end
        if (data0_ld) begin o_ld++; o_d0 = data0_in; end
        if (cpu_halt_req) o_halt++;
        if (cpu_resume_req) o_res++;
        if (cpu_halt_req && cpu_resume_req) o_excl++;
        if (cmd_ready) o_busy_rdy++;
    endtask

    task automatic reset_check(input string name);
        #2 rst = 1'b0;
        #1;
        chk({name, "_ctl"}, 32'({cmd_ready, rsp_valid, rsp_err, cpu_halt_req,
                                 cpu_resume_req, rf_we, data0_ld}), 32'b1000000);
        chk({name, "_bus"}, rf_wdata | data0_in | {26'b0, rf_addr}, 32'h0);
        sb.delete();
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({name, "_rdy"}, 32'(cmd_ready), 32'h1);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        exp_t  e, g;
        string t;
        logic  got;
        t = $sformatf("v%0d_", id);
        @(negedge clk);
        halt_delay   = v.hd;
        resume_delay = v.rd;
        req_cnt      = 0;
        cpu_halted   = v.halted;
        rsp_ready    = 1'b1;
        cmd_valid    = 1'b1;
        cmd_write    = v.wr;
        cmd_regno    = v.regno;
        cmd_wdata    = v.wdata;
        chk({t, "cmd_ready_idle"}, 32'(cmd_ready), 32'h1);
        e.err = v.err; e.we_n = v.we_n; e.ld_n = v.ld_n; e.d0 = v.d0;
        e.wa = v.regno; e.wd = v.wdata; e.halt_n = v.halt_n; e.res_n = v.res_n;
        e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        // Junk command held while busy; it must be ignored.
        #1;
        cmd_write = 1'b1;
        cmd_regno = 6'd2;
        cmd_wdata = 32'hBAD0BAD0;
        o_we = 0; o_ld = 0; o_halt = 0; o_res = 0; o_excl = 0; o_busy_rdy = 0;
        o_d0 = '0; o_wd = '0; o_wa = '0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got       = 1'b1;
                cmd_valid = 1'b0;
                g = sb.pop_front();
                chk({t, "rsp_err"}, 32'(rsp_err), 32'(g.err));
                chk({t, "we_count"}, o_we, g.we_n);
                if (g.we_n > 0) begin
                    chk({t, "we_addr"}, 32'(o_wa), 32'(g.wa));
                    chk({t, "we_data"}, o_wd, g.wd);
                end
                chk({t, "ld_count"}, o_ld, g.ld_n);
                if (g.ld_n > 0) chk({t, "data0_in"}, o_d0, g.d0);
                chk({t, "halt_cycles"}, o_halt, g.halt_n);
                chk({t, "resume_cycles"}, o_res, g.res_n);
                chk({t, "latency"}, c + 1, g.lat);
                chk({t, "req_in_resp"}, 32'({cpu_halt_req, cpu_resume_req}), 32'h0);
                chk({t, "req_overlap"}, o_excl, 0);
                chk({t, "ready_busy"}, o_busy_rdy, 0);
            end else begin
                observe();
                core_step();
            end
        end
        chk({t, "rsp_seen"}, 32'(got), 32'h1);
        if (!got) begin
            reset_check({t, "recover"});
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf_mem[i] = 32'hA5000000 | i;
        rf_mem[0]  = 32'hFFFFFFFF;
        rf_mem[5]  = 32'hDEADBEEF;
        rf_mem[12] = 32'h0C0C0C0C;
        rf_mem[31] = 32'hCAFEF00D;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           wr  reg wdata          hlt hd rd err we ld d0             hlt res lat
        vecs[0]  = mk(0,  5, 32'h0,          0, 3, 2, 0, 0, 1, 32'hDEADBEEF, 4, 2, 7);
        vecs[1]  = mk(1,  7, 32'h12345678,   1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 2);
        vecs[2]  = mk(1,  0, 32'h55AA55AA,   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 2);
        vecs[3]  = mk(0,  0, 32'h0,          1, 0, 0, 0, 0, 1, 32'h0,        0, 0, 2);
        vecs[4]  = mk(0,  9, 32'h0,          0, 0, 0, 1, 0, 0, 32'h0,        8, 0, 9);
        vecs[5]  = mk(0, 40, 32'h0,          0, 3, 2, 1, 0, 0, 32'h0,        0, 0, 1);
        vecs[6]  = mk(0, 32, 32'h0,          1, 0, 0, 1, 0, 0, 32'h0,        0, 0, 1);
        vecs[7]  = mk(0, 31, 32'h0,          1, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 2);
        vecs[8]  = mk(1,  3, 32'hA1B2C3D4,   0, 1, 0, 1, 1, 0, 32'h0,        2, 8, 11);
        vecs[9]  = mk(0, 12, 32'h0,          0, 8, 1, 0, 0, 1, 32'h0C0C0C0C, 9, 1, 11);
        vecs[10] = mk(1, 31, 32'hFFFF0000,   0, 2, 3, 0, 1, 0, 32'h0,        3, 3, 7);
        vecs[11] = mk(0, 63, 32'h0,          0, 1, 1, 1, 0, 0, 32'h0,        0, 0, 1);

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_regno = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; cpu_halted = 1'b0;
        halt_delay = 0; resume_delay = 0; req_cnt = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({cmd_ready, rsp_valid, rsp_err, cpu_halt_req,
                              cpu_resume_req, rf_we, data0_ld}), 32'b1000000);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset while waiting for the core to halt.
        @(negedge clk);
        halt_delay = 0; req_cnt = 0; cpu_halted = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_regno = 6'd9;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            core_step();
        end
        chk("rstA_in_halt", 32'(cpu_halt_req), 32'h1);
        reset_check("rstA");
        run_vec(20, vecs[0]);

        // Reset while a response is pending and the host stalls.
        @(negedge clk);
        cpu_halted = 1'b1; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_regno = 6'd40;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstB_rsp1", 32'({rsp_valid, rsp_err}), 32'b11);
        @(negedge clk);
        chk("rstB_rsp2", 32'({rsp_valid, rsp_err, cpu_halt_req}), 32'b110);
        reset_check("rstB");
        run_vec(21, vecs[1]);
        run_vec(22, vecs[9]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dbg_access_ctrl.md
Name: dbg_access_ctrl

Overview:
- Sequences debug-host abstract register accesses against the core's general-purpose register file.
- Per command: halt the core if needed, perform one GPR read or write through the debug register-file port, then restore run state.
- Read data is captured into the debugger's load-enabled data0 holding register via a one-cycle load pulse.
- Sits between the debug transport (command/response handshake) and the core halt/resume interface inside the Debugger Module.

Parameters:
- DATA_W, 32, GPR and data0 width.
- ADDR_W, 5, regno width.
- NUM_REGS, 32, number of valid GPRs; regno >= NUM_REGS is an error.
- HALT_TIMEOUT, 255, cycles to wait for cpu_halted / resume before aborting; counter width is clog2(HALT_TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller accepts command.
- cmd_write  in  1  1 = write GPR, 0 = read GPR.
- cmd_regno  in  ADDR_W  target GPR index.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_err  out  1  command failed (bad regno or timeout).
- cpu_halt_req  out  1  level request to halt the core.
- cpu_resume_req  out  1  level request to resume the core.
- cpu_halted  in  1  core is halted.
- rf_addr  out  ADDR_W  debug register-file address.
- rf_we  out  1  debug register-file write enable.
- rf_wdata  out  DATA_W  debug register-file write data.
- rf_rdata  in  DATA_W  debug register-file read data, combinational from rf_addr.
- data0_ld  out  1  load pulse to data0 register.
- data0_in  out  DATA_W  value to load into data0.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 except cmd_ready=1. Command latches and timeout counter cleared. Reset mid-command abandons it silently: no rf_we, no data0_ld, no response, halt/resume requests drop immediately.
- States: IDLE, HALT, ACCESS, RESUME, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch write/regno/wdata and record was_halted=cpu_halted.
  - regno>=NUM_REGS -> RESP with err=1; core untouched.
  - Else if cpu_halted -> ACCESS.
  - Else -> HALT.
- HALT: cpu_halt_req=1, counter increments each cycle.
  - cpu_halted=1 -> ACCESS, counter cleared.
  - Counter reaches HALT_TIMEOUT with cpu_halted=0 -> RESP with err=1; cpu_halt_req drops.
- ACCESS: exactly one cycle, rf_addr=regno, cpu_halt_req held.
  - Write: rf_we=1, rf_wdata=wdata. regno 0 writes are suppressed (rf_we=0) and still report success.
  - Read: data0_ld=1, data0_in=rf_rdata. regno 0 loads 0.
  - Next: was_halted=1 -> RESP; else -> RESUME.
- RESUME: cpu_halt_req=0, cpu_resume_req=1, counter runs.
  - cpu_halted=0 -> RESP, err=0.
  - Timeout -> RESP with err=1. Data already transferred remains valid.
- RESP: rsp_valid=1, rsp_err stable. On rsp_ready -> IDLE the same edge; cmd_ready is 1 the following cycle.
- Command handling:
  - cmd_ready=0 outside IDLE, so back-to-back commands are throttled with no loss.
  - cmd_valid with cmd_ready=0 is ignored.
- Counter saturates at HALT_TIMEOUT. It is cleared on every state entry.
- cpu_halt_req and cpu_resume_req are never high together.
- Latency from a halted core (read, no halt needed): accept -> ACCESS 1 cycle -> rsp_valid on the 2nd cycle after accept.

Decomposition:
- Shared package dbg_pkg holds:
  - State encoding (IDLE/HALT/ACCESS/RESUME/RESP, 3 bits).
  - DATA_W/ADDR_W defaults.
  - Error code constants, reused by other Debugger Module controllers.
- One natural sub-module: dbg_timeout_cnt (clear, enable, saturating count, expired flag).
- The FSM and command latches stay in dbg_access_ctrl.

Test Plan:
- Running core, read regno 5 (rf holds 0xDEADBEEF), cpu_halted asserted 3 cycles after halt_req:
  - Required: halt_req high until halted, then one data0_ld with data0_in=0xDEADBEEF.
  - Then resume_req until halted=0, then rsp_valid with rsp_err=0.
- Already-halted core, write regno 7 data 0x12345678:
  - Required: rf_we exactly one cycle with addr 7 and data 0x12345678.
  - No halt_req and no resume_req; rsp_valid 2 cycles after accept; core stays halted.
- Write regno 0 and read regno 0 on a halted core:
  - Required: rf_we never asserted; read loads data0_in=0; both responses rsp_err=0.
- Core never halts, HALT_TIMEOUT=8:
  - Required: rsp_valid with rsp_err=1 after 8 cycles in HALT; no rf_we; no data0_ld; halt_req low in RESP.
- regno 40 with NUM_REGS=32 and ADDR_W=6:
  - Required: immediate RESP with err=1; halt_req never asserted.
- rst pulled low during HALT and again during RESP:
  - Required: all outputs return to reset values asynchronously; cmd_ready=1 after release; the next command completes normally.
